// File: rtl/spu_isa_pkg.sv
// SPU instruction-set helpers: opcode constants, field positions and
// the pipe-class / register-usage decode shared by the issue front end.
package spu_isa_pkg;

    typedef enum logic {PIPE_EVEN, PIPE_ODD} pipe_e;

    localparam int RR_OP_LSB   = 21;
    localparam int RI16_OP_LSB = 23;
    localparam int RI10_OP_LSB = 24;
    localparam int RB_LSB      = 14;
    localparam int RA_LSB      = 7;
    localparam int RT_LSB      = 0;
    localparam int REG_W       = 7;

    localparam logic [10:0] OP_A      = 11'b00011000000;
    localparam logic [10:0] OP_SF     = 11'b00001000000;
    localparam logic [10:0] OP_AND    = 11'b00011000001;
    localparam logic [10:0] OP_OR     = 11'b00001000001;
    localparam logic [10:0] OP_NOP    = 11'b01000000001;
    localparam logic [10:0] OP_LNOP   = 11'b00000000001;
    localparam logic [10:0] OP_SHLQBI = 11'b00111011011;
    localparam logic [8:0]  OP_IL     = 9'b010000001;
    localparam logic [8:0]  OP_BR     = 9'b001100100;
    localparam logic [7:0]  OP_AI     = 8'b00011100;
    localparam logic [7:0]  OP_LQD    = 8'b00110100;
    localparam logic [7:0]  OP_STQD   = 8'b00100100;

    function automatic logic [10:0] op11(input logic [31:0] i);
        return i[31:RR_OP_LSB];
    endfunction

    function automatic logic [8:0] op9(input logic [31:0] i);
        return i[31:RI16_OP_LSB];
    endfunction

    function automatic logic [7:0] op8(input logic [31:0] i);
        return i[31:RI10_OP_LSB];
    endfunction

    // RR forms that actually carry ra/rb operands (nop/lnop do not)
    function automatic logic is_rr_alu(input logic [31:0] i);
        return op11(i) == OP_A || op11(i) == OP_SF || op11(i) == OP_AND
            || op11(i) == OP_OR || op11(i) == OP_SHLQBI;
    endfunction

    function automatic pipe_e pipe_class(input logic [31:0] i);
        logic odd;
        odd = op11(i) == OP_LNOP || op11(i) == OP_SHLQBI
           || op8(i) == OP_LQD || op8(i) == OP_STQD || op9(i) == OP_BR;
        return odd ? PIPE_ODD : PIPE_EVEN;
    endfunction

    function automatic logic writes_rt(input logic [31:0] i);
        return is_rr_alu(i) || op8(i) == OP_AI
            || op8(i) == OP_LQD || op9(i) == OP_IL;
    endfunction

    function automatic logic reads_reg(input logic [31:0] i,
                                       input logic [REG_W-1:0] r);
        logic ra_hit;
        logic rb_hit;
        logic rt_hit;
        ra_hit = i[RA_LSB +: REG_W] == r;
        rb_hit = i[RB_LSB +: REG_W] == r;
        rt_hit = i[RT_LSB +: REG_W] == r;
        return (is_rr_alu(i) && (ra_hit || rb_hit))
            || ((op8(i) == OP_AI || op8(i) == OP_LQD) && ra_hit)
            || (op8(i) == OP_STQD && (ra_hit || rt_hit));
    endfunction

endpackage

// File: rtl/spu_issue_buffer_if.sv
// Fetch-beat and issue-slot bundles for the SPU issue buffer.
interface spu_fetch_if #(parameter int WIDTH = 32);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr0;
    logic [WIDTH-1:0] instr1;

    modport master (output valid, pc, instr0, instr1, input ready);
    modport slave  (input valid, pc, instr0, instr1, output ready);
endinterface

interface spu_issue_if #(parameter int WIDTH = 32);
    logic             stall;
    logic             ev_valid;
    logic [WIDTH-1:0] ev_instr;
    logic [WIDTH-1:0] ev_pc;
    logic             od_valid;
    logic [WIDTH-1:0] od_instr;
    logic [WIDTH-1:0] od_pc;

    modport master (input stall,
                    output ev_valid, ev_instr, ev_pc,
                    output od_valid, od_instr, od_pc);
    modport slave  (output stall,
                    input ev_valid, ev_instr, ev_pc,
                    input od_valid, od_instr, od_pc);
endinterface

// File: rtl/spu_issue_buffer_pair_check.sv
// Dual-issue decision for the two head words of the issue queue.
module spu_pair_check
    import spu_isa_pkg::*;
#(
    parameter int CW      = 4,
    parameter int REGBITS = 7
) (
    input  logic [31:0]   h0_instr_i,
    input  logic          h0_pc2_i,
    input  logic [31:0]   h1_instr_i,
    input  logic [CW-1:0] count_i,
    output logic          dual_o,
    output logic          single_o,
    output logic          h0_odd_o
);

    logic hazard;
    logic h0_even;
    logic h1_odd;

    assign hazard  = writes_rt(h0_instr_i)
                  && reads_reg(h1_instr_i, h0_instr_i[REGBITS-1:0]);
    assign h0_even = pipe_class(h0_instr_i) == PIPE_EVEN;
    assign h1_odd  = pipe_class(h1_instr_i) == PIPE_ODD;
    assign h0_odd_o = !h0_even;

    // pairing only from an aligned beat boundary: even word first
    assign dual_o   = count_i >= CW'(2) && !h0_pc2_i
                   && h0_even && h1_odd && !hazard;
    assign single_o = count_i != '0 && !dual_o;

endmodule

// File: rtl/spu_issue_buffer.sv
// SPU issue buffer: fetch-beat queue with even/odd dual issue.
// SPU_ISSUE_STATS_EN adds saturating dual/single issue counters.
module spu_issue_buffer
    import spu_isa_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int REGBITS = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    spu_fetch_if.slave  fetch,
    spu_issue_if.master issue
`ifdef SPU_ISSUE_STATS_EN
    ,
    output logic [31:0] dual_cnt_o,
    output logic [31:0] single_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [WIDTH-1:0] instr_mem [DEPTH];

    logic [AW-1:0]    head_q, head_d, tail_q, tail_d, head1;
    logic [CW-1:0]    count_q, count_d, pops;
    logic             push, go, dual, single, h0_odd;

    logic             ev_valid_q, ev_valid_d, od_valid_q, od_valid_d;
    logic [WIDTH-1:0] ev_instr_q, ev_instr_d, ev_pc_q, ev_pc_d;
    logic [WIDTH-1:0] od_instr_q, od_instr_d, od_pc_q, od_pc_d;

    assign fetch.ready = (CW'(DEPTH) - count_q) >= CW'(2);
    assign push  = fetch.valid && fetch.ready && !flush_i;
    assign go    = !issue.stall && !flush_i;
    assign head1 = head_q + AW'(1);

    spu_pair_check #(.CW(CW), .REGBITS(REGBITS)) u_pair (
        .h0_instr_i (instr_mem[head_q]),
        .h0_pc2_i   (pc_mem[head_q][2]),
        .h1_instr_i (instr_mem[head1]),
        .count_i    (count_q),
        .dual_o     (dual),
        .single_o   (single),
        .h0_odd_o   (h0_odd)
    );

    always_comb begin
        pops = '0;
        if (go && dual)
            pops = CW'(2);
        else if (go && single)
            pops = CW'(1);
        head_d  = head_q + pops[AW-1:0];
        tail_d  = push ? tail_q + AW'(2) : tail_q;
        count_d = count_q + (push ? CW'(2) : CW'(0)) - pops;
        if (flush_i) begin
            count_d = '0;
            head_d  = tail_q;
            tail_d  = tail_q;
        end
    end

    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_instr_d = ev_instr_q;
        ev_pc_d    = ev_pc_q;
        od_valid_d = od_valid_q;
        od_instr_d = od_instr_q;
        od_pc_d    = od_pc_q;
        if (flush_i) begin
            ev_valid_d = 1'b0;
            od_valid_d = 1'b0;
        end else if (!issue.stall) begin
            ev_valid_d = 1'b0;
            od_valid_d = 1'b0;
            if (dual || (single && !h0_odd)) begin
                ev_valid_d = 1'b1;
                ev_instr_d = instr_mem[head_q];
                ev_pc_d    = pc_mem[head_q];
            end
            if (dual) begin
                od_valid_d = 1'b1;
                od_instr_d = instr_mem[head1];
                od_pc_d    = pc_mem[head1];
            end else if (single && h0_odd) begin
                od_valid_d = 1'b1;
                od_instr_d = instr_mem[head_q];
                od_pc_d    = pc_mem[head_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]              <= fetch.pc;
            instr_mem[tail_q]           <= fetch.instr0;
            pc_mem[tail_q + AW'(1)]     <= fetch.pc + WIDTH'(4);
            instr_mem[tail_q + AW'(1)]  <= fetch.instr1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ev_valid_q <= 1'b0;
            ev_instr_q <= '0;
            ev_pc_q    <= '0;
            od_valid_q <= 1'b0;
            od_instr_q <= '0;
            od_pc_q    <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ev_valid_q <= ev_valid_d;
            ev_instr_q <= ev_instr_d;
            ev_pc_q    <= ev_pc_d;
            od_valid_q <= od_valid_d;
            od_instr_q <= od_instr_d;
            od_pc_q    <= od_pc_d;
        end
    end

    assign issue.ev_valid = ev_valid_q;
    assign issue.ev_instr = ev_instr_q;
    assign issue.ev_pc    = ev_pc_q;
    assign issue.od_valid = od_valid_q;
    assign issue.od_instr = od_instr_q;
    assign issue.od_pc    = od_pc_q;

`ifdef SPU_ISSUE_STATS_EN
    logic [31:0] dual_cnt_q, dual_cnt_d, single_cnt_q, single_cnt_d;

    always_comb begin
        dual_cnt_d   = dual_cnt_q;
        single_cnt_d = single_cnt_q;
        if (go && dual && dual_cnt_q != '1)
            dual_cnt_d = dual_cnt_q + 32'd1;
        if (go && single && single_cnt_q != '1)
            single_cnt_d = single_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dual_cnt_q   <= '0;
            single_cnt_q <= '0;
        end else begin
            dual_cnt_q   <= dual_cnt_d;
            single_cnt_q <= single_cnt_d;
        end
    end

    assign dual_cnt_o   = dual_cnt_q;
    assign single_cnt_o = single_cnt_q;
`endif

`ifndef SYNTHESIS
    // fetch_ready gating keeps the occupancy inside the ring
    a_count_bounds: assert property (@(posedge clk) disable iff (reset)
        count_q <= CW'(DEPTH) && pops <= count_q);
`endif

endmodule

// File: tb/tb_spu_issue_buffer.sv
// Directed table-driven bench for spu_issue_buffer.
module tb_spu_issue_buffer;

    localparam logic [10:0] A_OP    = 11'b00011000000;
    localparam logic [10:0] LNOP_OP = 11'b00000000001;
    localparam logic [7:0]  AI_OP   = 8'b00011100;
    localparam logic [7:0]  LQD_OP  = 8'b00110100;
    localparam logic [7:0]  STQD_OP = 8'b00100100;

    typedef struct {
        logic        fl;
        logic        fv;
        logic        st;
        logic [31:0] pc;
        logic [31:0] i0;
        logic [31:0] i1;
        logic        rdy;
        logic        evv;
        logic [31:0] evpc;
        logic [31:0] evi;
        logic        odv;
        logic [31:0] odpc;
        logic [31:0] odi;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int   errors = 0;
    int   checks = 0;
    vec_t v[$];

    spu_fetch_if #(.WIDTH(32)) fif ();
    spu_issue_if #(.WIDTH(32)) iif ();

`ifdef SPU_ISSUE_STATS_EN
    logic [31:0] dual_cnt;
    logic [31:0] single_cnt;
`endif

    spu_issue_buffer dut (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush),
        .fetch   (fif),
        .issue   (iif)
`ifdef SPU_ISSUE_STATS_EN
        ,
        .dual_cnt_o   (dual_cnt),
        .single_cnt_o (single_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rr(logic [10:0] op, logic [6:0] rb,
                                       logic [6:0] ra, logic [6:0] rt);
        return {op, rb, ra, rt};
    endfunction

    function automatic logic [31:0] ri10(logic [7:0] op, logic [9:0] imm,
                                         logic [6:0] ra, logic [6:0] rt);
        return {op, imm, ra, rt};
    endfunction

    function automatic logic [31:0] lq(logic [31:0] pc);
        return ri10(LQD_OP, 10'd0, 7'd1, pc[8:2]);
    endfunction

    function automatic vec_t mk(logic fl, logic fv, logic st,
                                logic [31:0] pc, logic [31:0] i0,
                                logic [31:0] i1, logic rdy,
                                logic evv, logic [31:0] evpc,
                                logic [31:0] evi, logic odv,
                                logic [31:0] odpc, logic [31:0] odi);
        vec_t r;
        r.fl = fl; r.fv = fv; r.st = st;
        r.pc = pc; r.i0 = i0; r.i1 = i1;
        r.rdy = rdy; r.evv = evv; r.evpc = evpc; r.evi = evi;
        r.odv = odv; r.odpc = odpc; r.odi = odi;
        return r;
    endfunction

    task automatic chk(string nm, int row, logic [31:0] act,
                       logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
        end
    endtask

    task automatic run_row(int r);
        @(negedge clk);
        flush      = v[r].fl;
        fif.valid  = v[r].fv;
        fif.pc     = v[r].pc;
        fif.instr0 = v[r].i0;
        fif.instr1 = v[r].i1;
        iif.stall  = v[r].st;
        @(posedge clk);
        #1;
        chk("fetch_ready", r, 32'(fif.ready), 32'(v[r].rdy));
        chk("ev_valid", r, 32'(iif.ev_valid), 32'(v[r].evv));
        chk("od_valid", r, 32'(iif.od_valid), 32'(v[r].odv));
        if (v[r].evv) begin
            chk("ev_pc", r, iif.ev_pc, v[r].evpc);
            chk("ev_instr", r, iif.ev_instr, v[r].evi);
        end
        if (v[r].odv) begin
            chk("od_pc", r, iif.od_pc, v[r].odpc);
            chk("od_instr", r, iif.od_instr, v[r].odi);
        end
    endtask

    initial begin
        logic [31:0] a1, l1, ai4, st4, l7, a8, a9, l10, ln, a5, p;

        a1  = rr(A_OP, 7'd2, 7'd1, 7'd3);
        l1  = ri10(LQD_OP, 10'd0, 7'd1, 7'd5);
        ai4 = ri10(AI_OP, 10'd1, 7'd4, 7'd4);
        st4 = ri10(STQD_OP, 10'd0, 7'd6, 7'd4);
        l7  = ri10(LQD_OP, 10'd0, 7'd2, 7'd7);
        a8  = rr(A_OP, 7'd2, 7'd1, 7'd8);
        a9  = rr(A_OP, 7'd2, 7'd1, 7'd9);
        l10 = ri10(LQD_OP, 10'd0, 7'd1, 7'd10);
        ln  = rr(LNOP_OP, 7'd0, 7'd0, 7'd0);
        a5  = rr(A_OP, 7'd2, 7'd1, 7'd5);

        // independent even/odd pair, then RAW pair, then odd-first pair
        v.push_back(mk(0,1,0, 32'h00, a1, l1,  1, 0,0,0,       0,0,0));
        v.push_back(mk(0,0,0, 0, 0, 0,         1, 1,32'h00,a1, 1,32'h04,l1));
        v.push_back(mk(0,1,0, 32'h08, ai4,st4, 1, 0,0,0,       0,0,0));
        v.push_back(mk(0,0,0, 0, 0, 0,         1, 1,32'h08,ai4,0,0,0));
        v.push_back(mk(0,0,0, 0, 0, 0,         1, 0,0,0,       1,32'h0C,st4));
        v.push_back(mk(0,1,0, 32'h10, l7, a8,  1, 0,0,0,       0,0,0));
        v.push_back(mk(0,0,0, 0, 0, 0,         1, 0,0,0,       1,32'h10,l7));
        v.push_back(mk(0,0,0, 0, 0, 0,         1, 1,32'h14,a8, 0,0,0));
        v.push_back(mk(0,0,0, 0, 0, 0,         1, 0,0,0,       0,0,0));
        // stall with a full queue, then drain across the wrap point
        v.push_back(mk(0,1,0, 32'h20, a9, l10, 1, 0,0,0,       0,0,0));
        v.push_back(mk(0,1,0, 32'h28, lq(32'h28), lq(32'h2C),
                       1, 1,32'h20,a9, 1,32'h24,l10));
        for (int k = 0; k < 3; k++) begin
            p = 32'h30 + 32'(k * 8);
            v.push_back(mk(0,1,1, p, lq(p), lq(p + 4), k != 2,
                           1,32'h20,a9, 1,32'h24,l10));
        end
        v.push_back(mk(0,1,1, 32'h48, lq(32'h48), lq(32'h4C), 0,
                       1,32'h20,a9, 1,32'h24,l10));
        for (int k = 0; k < 8; k++) begin
            p = 32'h28 + 32'(k * 4);
            v.push_back(mk(0,0,0, 0,0,0, k != 0, 0,0,0, 1,p,lq(p)));
        end
        v.push_back(mk(0,0,0, 0, 0, 0,         1, 0,0,0,       0,0,0));
        // flush with six words queued and a push in the same cycle
        for (int k = 0; k < 3; k++) begin
            p = 32'h100 + 32'(k * 8);
            v.push_back(mk(0,1,1, p, lq(p), lq(p + 4), 1, 0,0,0, 0,0,0));
        end
        v.push_back(mk(1,1,0, 32'h200, lq(32'h200), lq(32'h204),
                       1, 0,0,0, 0,0,0));
        v.push_back(mk(0,0,0, 0, 0, 0,         1, 0,0,0,       0,0,0));
        v.push_back(mk(0,0,0, 0, 0, 0,         1, 0,0,0,       0,0,0));
        // even word at pc[2]=1 must not pair with the next beat
        v.push_back(mk(0,1,0, 32'h300, ln, a5, 1, 0,0,0,       0,0,0));
        v.push_back(mk(0,1,0, 32'h308, lq(32'h308), lq(32'h30C),
                       1, 0,0,0, 1,32'h300,ln));
        v.push_back(mk(0,0,0, 0, 0, 0,         1, 1,32'h304,a5, 0,0,0));
        v.push_back(mk(0,0,0, 0, 0, 0,         1, 0,0,0, 1,32'h308,lq(32'h308)));
        v.push_back(mk(0,0,0, 0, 0, 0,         1, 0,0,0, 1,32'h30C,lq(32'h30C)));
        v.push_back(mk(0,0,0, 0, 0, 0,         1, 0,0,0,       0,0,0));

        fif.valid  = 1'b0;
        fif.pc     = '0;
        fif.instr0 = '0;
        fif.instr1 = '0;
        iif.stall  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ev_valid", -1, 32'(iif.ev_valid), 32'd0);
        chk("rst_od_valid", -1, 32'(iif.od_valid), 32'd0);
        chk("rst_ev_pc", -1, iif.ev_pc, 32'd0);
        chk("rst_od_instr", -1, iif.od_instr, 32'd0);
        chk("rst_ready", -1, 32'(fif.ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        for (int r = 0; r < 9; r++)
            run_row(r);
`ifdef SPU_ISSUE_STATS_EN
        chk("dual_cnt", 8, dual_cnt, 32'd1);
        chk("single_cnt", 8, single_cnt, 32'd4);
`endif
        for (int r = 9; r < v.size(); r++)
            run_row(r);

        @(negedge clk);
        fif.valid = 1'b0;
        iif.stall = 1'b0;
        flush     = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
